// File: rtl/riscv_pkg.sv
// Shared pipeline constants: datapath geometry, writeback result-select
// encodings and the hardwired-zero register index.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result selector: picks ALU, load data or link value for commit.
module wb_result_mux
    import riscv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] alu_i,
    input  logic [W-1:0] mem_i,
    input  logic [W-1:0] pc4_i,
    output logic [W-1:0] result_o
);

    // 4:1 select; the reserved 2'b11 encoding falls back to the ALU result
    always_comb begin
        result_o = alu_i;
        case (sel_i)
            RES_ALU: result_o = alu_i;
            RES_MEM: result_o = mem_i;
            RES_PC4: result_o = pc4_i;
            default: result_o = alu_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus architectural integer register file: commits the
// selected result, serves two write-first bypassed decode read ports.
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS,
    parameter int CNTW  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUresultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [4:0]      RdW,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    output logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [CNTW-1:0] WrCountW
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            wen_s;

    wb_result_mux #(.W(XLEN)) u_result_mux (
        .sel_i    (ResultSrcW),
        .alu_i    (ALUresultW),
        .mem_i    (ReadDataW),
        .pc4_i    (PCPlus4W),
        .result_o (ResultW)
    );

    assign wen_s = RegWriteW && (RdW != REG_ZERO);

    // Next-state of the array; entry 0 is pinned to zero so it never holds data
    always_comb begin
        regs_d = regs_q;
        if (wen_s) begin
            regs_d[RdW] = ResultW;
        end else begin
            regs_d[RdW] = regs_q[RdW];
        end
        regs_d[0] = '0;
    end

    // Committed-write counter, wraps naturally at its width
    always_comb begin
        if (wen_s) begin
            cnt_d = cnt_q + CNTW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Register array and counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    // Write-first read ports: decode sees the value committed this same edge
    always_comb begin
        if (Rs1D == REG_ZERO) begin
            RD1D = '0;
        end else if (wen_s && (RdW == Rs1D)) begin
            RD1D = ResultW;
        end else begin
            RD1D = regs_q[Rs1D];
        end

        if (Rs2D == REG_ZERO) begin
            RD2D = '0;
        end else if (wen_s && (RdW == Rs2D)) begin
            RD2D = ResultW;
        end else begin
            RD2D = regs_q[Rs2D];
        end
    end

    assign WrCountW = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array/counter model.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUresultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] ResultW;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] WrCountW;
    logic [31:0] ResultW4;
    logic [31:0] RD1D4;
    logic [31:0] RD2D4;
    logic [3:0]  WrCountW4;

    int total_cnt;
    int bad_cnt;

    // Reference state: architectural registers and committed-write count
    logic [31:0] mdl_reg [32];
    logic [31:0] mdl_cnt;

    wb_regfile u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUresultW (ALUresultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .ResultW    (ResultW),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .WrCountW   (WrCountW)
    );

    // Narrow-counter build exercises the wrap from all-ones to zero
    wb_regfile #(.CNTW(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUresultW (ALUresultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .ResultW    (ResultW4),
        .RD1D       (RD1D4),
        .RD2D       (RD2D4),
        .WrCountW   (WrCountW4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sel_result(input logic [1:0] src, input logic [31:0] alu,
                                               input logic [31:0] mem, input logic [31:0] pc4);
        if (src == 2'b01) return mem;
        if (src == 2'b10) return pc4;
        return alu;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] rs, input logic wen,
                                             input logic [4:0] rd, input logic [31:0] res);
        if (rs == 5'd0) return 32'd0;
        if (wen && rd == rs) return res;
        return mdl_reg[rs];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl_reg[i] = 32'd0;
        mdl_cnt = 32'd0;
    endtask

    // One cycle: drive at negedge, check combinational view, commit model at posedge
    task automatic step(input logic we, input logic [1:0] src, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc4,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        logic [31:0] res;
        logic        wen;
        RegWriteW  = we;
        ResultSrcW = src;
        ALUresultW = alu;
        ReadDataW  = mem;
        PCPlus4W   = pc4;
        RdW        = rd;
        Rs1D       = rs1;
        Rs2D       = rs2;
        #1;
        res = sel_result(src, alu, mem, pc4);
        wen = we && (rd != 5'd0);
        chk("result", ResultW, res);
        chk("rd1", RD1D, exp_read(rs1, wen, rd, res));
        chk("rd2", RD2D, exp_read(rs2, wen, rd, res));
        chk("count", WrCountW, mdl_cnt);
        chk("count4", {28'd0, WrCountW4}, {28'd0, mdl_cnt[3:0]});
        chk("rd1_n4", RD1D4, exp_read(rs1, wen, rd, res));
        @(posedge clk);
        if (wen) begin
            mdl_reg[rd] = res;
            mdl_cnt     = mdl_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    // Assert reset mid-cycle with a write pending; outputs must clear before any edge
    task automatic pulse_reset(input logic [4:0] rs1);
        RegWriteW  = 1'b1;
        ResultSrcW = 2'b00;
        ALUresultW = 32'd0;
        RdW        = 5'd5;
        Rs1D       = rs1;
        Rs2D       = rs1;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_rd1", RD1D, exp_read(rs1, 1'b1, 5'd5, 32'd0));
        chk("rst_count", WrCountW, 32'd0);
        chk("rst_count4", {28'd0, WrCountW4}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        model_clear();
        rst_n      = 1'b0;
        RegWriteW  = 1'b0;
        ResultSrcW = 2'b00;
        ALUresultW = 32'd0;
        ReadDataW  = 32'd0;
        PCPlus4W   = 32'd0;
        RdW        = 5'd0;
        Rs1D       = 5'd1;
        Rs2D       = 5'd31;
        #1;
        chk("reset_result", ResultW, 32'd0);
        chk("reset_rd1", RD1D, 32'd0);
        chk("reset_rd2", RD2D, 32'd0);
        chk("reset_count", WrCountW, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset clear of a written register
        step(1'b1, 2'b00, 32'hDEADBEEF, 32'd0, 32'd0, 5'd5, 5'd0, 5'd0);
        step(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
        pulse_reset(5'd5);
        step(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd7);

        // Result select over all four encodings into x7
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 2'(s), 32'h11, 32'h22, 32'h33, 5'd7, 5'd7, 5'd7);
        end
        step(1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd0);
        chk("sel_count", WrCountW, 32'd4);

        // x0 protection
        step(1'b1, 2'b00, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7);

        // Same-cycle bypass on both ports
        step(1'b1, 2'b00, 32'h1, 32'd0, 32'd0, 5'd3, 5'd3, 5'd3);
        step(1'b1, 2'b00, 32'hA5A5A5A5, 32'd0, 32'd0, 5'd3, 5'd3, 5'd3);
        step(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3, 5'd3);

        // Disabled write leaves the target and counter alone
        step(1'b1, 2'b00, 32'h99, 32'd0, 32'd0, 5'd9, 5'd0, 5'd0);
        step(1'b0, 2'b00, 32'h5, 32'd0, 32'd0, 5'd9, 5'd9, 5'd9);
        step(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd3);

        // Narrow counter wrap after sixteen commits from a clean reset
        pulse_reset(5'd0);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 2'b10, 32'd0, 32'd0, 32'(i + 100), 5'(1 + i % 31), 5'd1, 5'd2);
        end
        chk("wrap4_after16plus1", {28'd0, WrCountW4}, 32'd1);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                pulse_reset(5'($urandom_range(0, 31)));
            end else begin
                step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
                     $urandom, 5'($urandom_range(0, 31)),
                     ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)));
            end
        end

        // Final sweep of every register through both ports
        for (int r = 0; r < 32; r++) begin
            step(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 5'(r), 5'(31 - r));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline boundary: takes the registered writeback-stage bundle and selects the writeback result.
- Commits the result into the 32 x 32-bit architectural integer register file.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass, so WB-to-ID hazards need no stall.
- Keeps a committed-write counter for debug and performance visibility.

Parameters:
- XLEN, 32, data width of registers and result paths.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- CNTW, 32, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RegWriteW  input  1  writeback enable from the MEM/WB register.
- ResultSrcW  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 ALU.
- ALUresultW  input  XLEN  ALU result.
- ReadDataW  input  XLEN  data-memory load data.
- PCPlus4W  input  XLEN  link value for jal/jalr.
- RdW  input  5  destination register index.
- Rs1D  input  5  decode-stage source register 1 index.
- Rs2D  input  5  decode-stage source register 2 index.
- ResultW  output  XLEN  selected writeback value (combinational); also feeds the EX forwarding mux.
- RD1D  output  XLEN  read data for Rs1D (combinational).
- RD2D  output  XLEN  read data for Rs2D (combinational).
- WrCountW  output  CNTW  number of committed register writes since reset.

Behaviour:
- Reset:
  - One clock domain; the reset is asynchronous and active-low.
  - rst_n low immediately clears x1..x31 and WrCountW to 0, independent of clk.
  - Combinational outputs follow from the cleared state; with ResultSrcW=00 and ALUresultW=0, ResultW is 0.
  - Any write in flight when reset asserts is dropped.
- Result select (combinational):
  - 00 -> ALUresultW; 01 -> ReadDataW; 10 -> PCPlus4W.
  - 11 -> ALUresultW; reserved, lui/auipc already resolve in the ALU.
- Commit condition: wen = RegWriteW && (RdW != 0).
- Write:
  - On posedge clk with rst_n high and wen: reg[RdW] <= ResultW.
  - Exactly one write per cycle; latency one edge.
- x0 handling:
  - Writes to RdW=0 are discarded and the counter does not increment.
  - Reads of index 0 always return 0.
- Reads: combinational from the register array.
  - RD1D = 0 if Rs1D==0; else ResultW if wen && RdW==Rs1D; else reg[Rs1D].
  - RD2D uses the same rule with Rs2D.
- Bypass: write-first within the cycle, so decode sees the value being committed that same cycle. This replaces the negedge-write scheme and is the mandated behaviour.
- Rs1D==Rs2D==RdW with wen: both ports return ResultW.
- Counter:
  - WrCountW increments by 1 on every posedge where wen is true.
  - Wraps from 2^CNTW-1 to 0 with no sticky flag.
- No X propagation: all registers have defined reset values. Unknown ResultSrcW encodings never occur, because all four encodings are defined.
- No stall or flush inputs: a bubble arrives as RegWriteW=0 from upstream.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and NREGS.
  - ResultSrc encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
  - The x0 index constant REG_ZERO.
- One natural sub-module: wb_result_mux, the 4:1 ResultSrcW selector.
- The register array, bypass and counter stay in wb_regfile.

Test Plan:
- Reset clear: write x5=32'hDEADBEEF, then pulse rst_n low mid-cycle -> RD1D for Rs1D=5 reads 0 immediately; WrCountW=0.
- Result select: ALU=32'h11, Mem=32'h22, PC4=32'h33, stepping ResultSrcW 00/01/10/11 with RegWriteW=1, RdW=7 -> ResultW and reg x7 are 11, 22, 33, 11 on successive cycles; WrCountW advances by 4.
- x0 protection: RegWriteW=1, RdW=0, ALU=32'hFFFFFFFF -> Rs1D=0 reads 0; WrCountW unchanged.
- Same-cycle bypass: reg x3 holds 32'h1, then ResultW=32'hA5A5A5A5 with wen, RdW=3, Rs1D=Rs2D=3 -> RD1D=RD2D=32'hA5A5A5A5 in that cycle; the next cycle with RegWriteW=0 still reads A5A5A5A5.
- Disabled write: RegWriteW=0, RdW=9, ResultW=32'h5 -> x9 unchanged; RD1D shows the old value with no bypass; counter unchanged.
- Counter wrap: force WrCountW to 32'hFFFFFFFF (or CNTW=4 build at 4'hF), then one valid write -> WrCountW=0.
